// File: rtl/trdb_packet_sequencer.sv
// Trace-encoder packet-format sequencer: keeps a last/this/next instruction window,
// picks the packet format, and hands it to the emitter over a valid/ready handshake.
package trdb_pkg;
  typedef enum logic [1:0] {
    F_OPT_EXT    = 2'h0,
    F_DIFF_DELTA = 2'h1,
    F_ADDR_ONLY  = 2'h2,
    F_SYNC       = 2'h3
  } trdb_format_e;

  typedef enum logic [1:0] {
    SF_START   = 2'h0,
    SF_TRAP    = 2'h1,
    SF_CONTEXT = 2'h2,
    SF_SUPPORT = 2'h3
  } trdb_f_sync_subformat_e;

  typedef enum logic [1:0] {
    NO_CHANGE  = 2'h0,
    ENDED_REP  = 2'h1,
    TRACE_LOST = 2'h2,
    ENDED_NTR  = 2'h3
  } qual_status_e;
endpackage

module trdb_packet_sequencer
  import trdb_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RESYNC_MAX = 255,
  parameter bit          DIFF_ADDR  = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic                        qualified_i,
  input  logic                        exception_i,
  input  logic                        retired_i,
  input  logic                        privchange_i,
  input  logic                        updiscon_i,
  input  logic                        branch_map_empty_i,
  input  logic                        branch_map_full_i,
  input  logic                        enc_enabled_i,
  input  logic                        enc_disabled_i,
  input  logic                        opmode_change_i,
  input  logic [XLEN-1:0]             iaddr_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output trdb_format_e                packet_format_o,
  output trdb_f_sync_subformat_e      packet_f_sync_subformat_o,
  output logic                        thaddr_o,
  output logic                        lc_tc_mux_o,
  output qual_status_e                qual_status_o,
  output logic                        resync_timer_rst_o,
  output logic [XLEN-1:0]             addr_o,
  output logic [$clog2(XLEN):0]       keep_bits_o
);

  localparam int unsigned CW = $clog2(RESYNC_MAX + 2);
  localparam int unsigned KW = $clog2(XLEN) + 1;

  typedef struct packed {
    logic            valid;
    logic            qualified;
    logic            exception;
    logic            retired;
    logic            privchange;
    logic            updiscon;
    logic            bm_empty;
    logic            bm_full;
    logic            enc_enabled;
    logic            enc_disabled;
    logic            opmode_change;
    logic [XLEN-1:0] iaddr;
  } sample_t;

  // Only the fields rules look at on the last-cycle instruction are kept.
  logic            lc_valid_q, lc_qualified_q, lc_exception_q, lc_updiscon_q;
  sample_t         tc_q, nc;
  logic            reported_q, ended_ntr_q, ended_rep_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] last_addr_q;

  logic                   valid_q, timer_rst_q;
  trdb_format_e           fmt_q;
  trdb_f_sync_subformat_e sf_q;
  logic                   thaddr_q, mux_q;
  qual_status_e           qs_q;
  logic [XLEN-1:0]        addr_q;
  logic [KW-1:0]          keep_q;

  logic accept, decide;
  logic tc_exc_only, tc_er_n, nc_exc_only, nc_ppccd_br, resync_br;
  logic lc_final_qualified, first_qualified, et_max, gt_max;
  logic emit, support, thaddr_d, mux_d, full_addr, set_ntr, set_rep, reported_d, sync_clr;
  trdb_format_e           fmt_d, diff_fmt;
  trdb_f_sync_subformat_e sf_d;
  qual_status_e           qs_d;
  logic [XLEN-1:0]        addr_d;
  logic [KW-1:0]          lz_pos, lz_neg, lz_max, keep_d;

  function automatic logic [KW-1:0] lzc(input logic [XLEN-1:0] v);
    logic [KW-1:0] n;
    logic          hit;
    n   = '0;
    hit = 1'b0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (v[i]) hit = 1'b1;
      else if (!hit) n = n + KW'(1);
    end
    return n;
  endfunction

  assign ready_o = !valid_q || ready_i;
  assign accept  = valid_i && ready_o;
  assign decide  = accept && tc_q.valid;

  always_comb begin
    nc               = '0;
    nc.valid         = 1'b1;
    nc.qualified     = qualified_i;
    nc.exception     = exception_i;
    nc.retired       = retired_i;
    nc.privchange    = privchange_i;
    nc.updiscon      = updiscon_i;
    nc.bm_empty      = branch_map_empty_i;
    nc.bm_full       = branch_map_full_i;
    nc.enc_enabled   = enc_enabled_i;
    nc.enc_disabled  = enc_disabled_i;
    nc.opmode_change = opmode_change_i;
    nc.iaddr         = iaddr_i;
  end

  assign tc_exc_only        = tc_q.exception && !tc_q.retired;
  assign tc_er_n            = tc_q.exception && tc_q.retired;
  assign nc_exc_only        = exception_i && !retired_i;
  assign nc_ppccd_br        = privchange_i && !branch_map_empty_i;
  assign et_max             = (cnt_q == CW'(RESYNC_MAX));
  assign gt_max             = (cnt_q > CW'(RESYNC_MAX));
  assign resync_br          = et_max && !tc_q.bm_empty;
  assign lc_final_qualified = lc_valid_q && lc_qualified_q && !tc_q.qualified;
  assign first_qualified    = !lc_valid_q || !lc_qualified_q;
  assign diff_fmt           = tc_q.bm_empty ? F_ADDR_ONLY : F_DIFF_DELTA;

  // Format priority; first matching rule wins.
  always_comb begin
    emit       = 1'b0;
    support    = 1'b0;
    fmt_d      = F_OPT_EXT;
    sf_d       = SF_START;
    thaddr_d   = 1'b0;
    mux_d      = 1'b0;
    qs_d       = NO_CHANGE;
    full_addr  = 1'b1;
    set_ntr    = 1'b0;
    set_rep    = 1'b0;
    reported_d = reported_q;
    if (tc_q.enc_enabled || tc_q.enc_disabled || tc_q.opmode_change || lc_final_qualified) begin
      emit    = 1'b1;
      support = 1'b1;
      fmt_d   = F_SYNC;
      sf_d    = SF_SUPPORT;
      qs_d    = ended_ntr_q ? ENDED_NTR : (ended_rep_q ? ENDED_REP : NO_CHANGE);
    end else if (tc_q.qualified) begin
      if (lc_valid_q && lc_exception_q) begin
        emit  = 1'b1;
        fmt_d = F_SYNC;
        if (tc_exc_only) begin
          sf_d       = SF_TRAP;
          reported_d = 1'b1;
        end else if (reported_q) begin
          sf_d       = SF_START;
          reported_d = 1'b0;
        end else begin
          sf_d       = SF_TRAP;
          thaddr_d   = 1'b1;
          reported_d = 1'b0;
        end
      end else if (first_qualified || tc_q.privchange || gt_max) begin
        emit  = 1'b1;
        fmt_d = F_SYNC;
        sf_d  = SF_START;
      end else if (lc_valid_q && lc_updiscon_q) begin
        emit    = 1'b1;
        set_ntr = 1'b1;
        if (tc_exc_only) begin
          fmt_d = F_SYNC;
          sf_d  = SF_TRAP;
          mux_d = 1'b1;
        end else begin
          fmt_d     = diff_fmt;
          full_addr = 1'b0;
        end
      end else if (resync_br || tc_er_n) begin
        emit      = 1'b1;
        fmt_d     = diff_fmt;
        full_addr = 1'b0;
      end else if (nc_exc_only || nc_ppccd_br || !qualified_i) begin
        emit      = 1'b1;
        fmt_d     = diff_fmt;
        full_addr = 1'b0;
        set_rep   = !qualified_i;
      end else if (tc_q.bm_full) begin
        emit      = 1'b1;
        fmt_d     = F_DIFF_DELTA;
        full_addr = 1'b0;
      end
    end
  end

  assign sync_clr = emit && (fmt_d == F_SYNC) && !support;

  always_comb begin
    addr_d = tc_q.iaddr;
    if (DIFF_ADDR && !full_addr) addr_d = tc_q.iaddr - last_addr_q;
    lz_pos = lzc(addr_d);
    lz_neg = lzc(~addr_d);
    lz_max = (lz_pos > lz_neg) ? lz_pos : lz_neg;
    keep_d = KW'(XLEN) - lz_max + KW'(1);
  end

  // Window, flags, resync counter and reference address only move on an accepted sample.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lc_valid_q     <= 1'b0;
      lc_qualified_q <= 1'b0;
      lc_exception_q <= 1'b0;
      lc_updiscon_q  <= 1'b0;
      tc_q           <= '0;
      reported_q     <= 1'b0;
      ended_ntr_q    <= 1'b0;
      ended_rep_q    <= 1'b0;
      cnt_q          <= '0;
      last_addr_q    <= '0;
    end else begin
      if (accept) begin
        lc_valid_q     <= tc_q.valid;
        lc_qualified_q <= tc_q.qualified;
        lc_exception_q <= tc_q.exception;
        lc_updiscon_q  <= tc_q.updiscon;
        tc_q           <= nc;
      end
      if (decide) begin
        reported_q <= reported_d;
        if (support) begin
          ended_ntr_q <= 1'b0;
          ended_rep_q <= 1'b0;
        end else begin
          if (set_ntr) ended_ntr_q <= 1'b1;
          if (set_rep) ended_rep_q <= 1'b1;
        end
        if (sync_clr) cnt_q <= '0;
        else if (tc_q.qualified && cnt_q != CW'(RESYNC_MAX + 1)) cnt_q <= cnt_q + CW'(1);
        if (emit && !support) last_addr_q <= tc_q.iaddr;
      end
    end
  end

  // Output slot: holds the packet until the emitter takes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= 1'b0;
      timer_rst_q <= 1'b0;
      fmt_q       <= F_OPT_EXT;
      sf_q        <= SF_START;
      thaddr_q    <= 1'b0;
      mux_q       <= 1'b0;
      qs_q        <= NO_CHANGE;
      addr_q      <= '0;
      keep_q      <= KW'(1);
    end else begin
      timer_rst_q <= decide && sync_clr;
      if (decide && emit) begin
        valid_q  <= 1'b1;
        fmt_q    <= fmt_d;
        sf_q     <= sf_d;
        thaddr_q <= thaddr_d;
        mux_q    <= mux_d;
        qs_q     <= qs_d;
        addr_q   <= addr_d;
        keep_q   <= keep_d;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_o                   = valid_q;
  assign packet_format_o           = fmt_q;
  assign packet_f_sync_subformat_o = sf_q;
  assign thaddr_o                  = thaddr_q;
  assign lc_tc_mux_o               = mux_q;
  assign qual_status_o             = qs_q;
  assign resync_timer_rst_o        = timer_rst_q;
  assign addr_o                    = addr_q;
  assign keep_bits_o               = keep_q;

endmodule

// File: tb/tb_trdb_packet_sequencer.sv
// Directed bench for trdb_packet_sequencer (RESYNC_MAX=4 so the resync path is reachable quickly).
module tb_trdb_packet_sequencer;
  import trdb_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0, ready_o;
  logic        qualified_i = 1'b0, exception_i = 1'b0, retired_i = 1'b0;
  logic        privchange_i = 1'b0, updiscon_i = 1'b0;
  logic        branch_map_empty_i = 1'b1, branch_map_full_i = 1'b0;
  logic        enc_enabled_i = 1'b0, enc_disabled_i = 1'b0, opmode_change_i = 1'b0;
  logic [31:0] iaddr_i = '0;
  logic        valid_o, ready_i = 1'b1;
  trdb_format_e           packet_format_o;
  trdb_f_sync_subformat_e packet_f_sync_subformat_o;
  logic        thaddr_o, lc_tc_mux_o, resync_timer_rst_o;
  qual_status_e qual_status_o;
  logic [31:0] addr_o;
  logic [5:0]  keep_bits_o;
  logic [47:0] obs_pkt, exp_pkt;

  int vectors = 0;
  int miscompares = 0;

  trdb_packet_sequencer #(.XLEN(32), .RESYNC_MAX(4), .DIFF_ADDR(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .qualified_i(qualified_i), .exception_i(exception_i), .retired_i(retired_i),
    .privchange_i(privchange_i), .updiscon_i(updiscon_i),
    .branch_map_empty_i(branch_map_empty_i), .branch_map_full_i(branch_map_full_i),
    .enc_enabled_i(enc_enabled_i), .enc_disabled_i(enc_disabled_i),
    .opmode_change_i(opmode_change_i), .iaddr_i(iaddr_i),
    .valid_o(valid_o), .ready_i(ready_i), .packet_format_o(packet_format_o),
    .packet_f_sync_subformat_o(packet_f_sync_subformat_o), .thaddr_o(thaddr_o),
    .lc_tc_mux_o(lc_tc_mux_o), .qual_status_o(qual_status_o),
    .resync_timer_rst_o(resync_timer_rst_o), .addr_o(addr_o), .keep_bits_o(keep_bits_o)
  );

  always #5 clk_i = ~clk_i;

  assign obs_pkt = {valid_o, packet_format_o, packet_f_sync_subformat_o, thaddr_o, lc_tc_mux_o,
                    qual_status_o, resync_timer_rst_o, addr_o, keep_bits_o};

  function automatic logic [47:0] pkt(input logic v, input trdb_format_e f,
                                      input trdb_f_sync_subformat_e sf, input logic th,
                                      input logic mx, input qual_status_e qs, input logic tr,
                                      input logic [31:0] a, input logic [5:0] k);
    return {v, f, sf, th, mx, qs, tr, a, k};
  endfunction

  task automatic do_reset();
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  // Presents one sample for exactly one clock edge; outputs are then observed 1 ns after it.
  task automatic send(input logic [31:0] a, input logic q, input logic exc, input logic ret,
                      input logic upd, input logic bme);
    iaddr_i = a; qualified_i = q; exception_i = exc; retired_i = ret;
    updiscon_i = upd; branch_map_empty_i = bme; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    send(32'hABC0, 1, 0, 1, 0, 1);
    send(32'hABC4, 1, 0, 1, 0, 1);
    do_reset();
    exp_pkt = pkt(0, F_OPT_EXT, SF_START, 0, 0, NO_CHANGE, 0, 32'h0, 6'd1);
    vectors++;
    if (obs_pkt !== exp_pkt) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", obs_pkt, exp_pkt);
    end
    vectors++;
    if (ready_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_ready: got %b expected 1", ready_o);
    end
  endtask

  task automatic test_first_sync();
    do_reset();
    send(32'h1000, 1, 0, 1, 0, 1);
    vectors++;
    if (valid_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL first_no_pkt: got valid %b expected 0", valid_o);
    end
    send(32'h1004, 1, 0, 1, 0, 1);
    exp_pkt = pkt(1, F_SYNC, SF_START, 0, 0, NO_CHANGE, 1, 32'h1000, 6'd14);
    vectors++;
    if (obs_pkt !== exp_pkt) begin
      miscompares++;
      $display("[TB] FAIL first_start: got %h expected %h", obs_pkt, exp_pkt);
    end
  endtask

  task automatic test_updiscon();
    do_reset();
    send(32'h1000, 1, 0, 1, 0, 1);
    send(32'h1004, 1, 0, 1, 0, 1);
    send(32'h1010, 1, 0, 1, 1, 1);
    send(32'h2000, 1, 0, 1, 0, 1);
    vectors++;
    if (valid_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL updiscon_quiet: got valid %b expected 0", valid_o);
    end
    send(32'h2004, 1, 0, 1, 0, 1);
    exp_pkt = pkt(1, F_ADDR_ONLY, SF_START, 0, 0, NO_CHANGE, 0, 32'h1000, 6'd14);
    vectors++;
    if (obs_pkt !== exp_pkt) begin
      miscompares++;
      $display("[TB] FAIL updiscon_addr_only: got %h expected %h", obs_pkt, exp_pkt);
    end
    send(32'h2008, 0, 0, 1, 0, 1);
    exp_pkt = pkt(1, F_ADDR_ONLY, SF_START, 0, 0, NO_CHANGE, 0, 32'h4, 6'd4);
    vectors++;
    if (obs_pkt !== exp_pkt) begin
      miscompares++;
      $display("[TB] FAIL qual_end_last: got %h expected %h", obs_pkt, exp_pkt);
    end
    send(32'h200C, 0, 0, 1, 0, 1);
    exp_pkt = pkt(1, F_SYNC, SF_SUPPORT, 0, 0, ENDED_NTR, 0, 32'h2008, 6'd15);
    vectors++;
    if (obs_pkt !== exp_pkt) begin
      miscompares++;
      $display("[TB] FAIL support_ntr: got %h expected %h", obs_pkt, exp_pkt);
    end
    send(32'h2010, 0, 0, 1, 0, 1);
    vectors++;
    if (valid_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL unqual_quiet: got valid %b expected 0", valid_o);
    end
  endtask

  task automatic test_exception();
    do_reset();
    send(32'h100, 1, 0, 1, 0, 1);
    send(32'h104, 1, 0, 1, 0, 1);
    exp_pkt = pkt(1, F_SYNC, SF_START, 0, 0, NO_CHANGE, 1, 32'h100, 6'd10);
    vectors++;
    if (obs_pkt !== exp_pkt) begin
      miscompares++;
      $display("[TB] FAIL exc_start: got %h expected %h", obs_pkt, exp_pkt);
    end
    send(32'h108, 1, 1, 1, 0, 1);
    send(32'h200, 1, 1, 0, 0, 1);
    exp_pkt = pkt(1, F_ADDR_ONLY, SF_START, 0, 0, NO_CHANGE, 0, 32'h8, 6'd5);
    vectors++;
    if (obs_pkt !== exp_pkt) begin
      miscompares++;
      $display("[TB] FAIL er_n_addr_only: got %h expected %h", obs_pkt, exp_pkt);
    end
    send(32'h300, 1, 0, 1, 0, 1);
    exp_pkt = pkt(1, F_SYNC, SF_TRAP, 0, 0, NO_CHANGE, 1, 32'h200, 6'd11);
    vectors++;
    if (obs_pkt !== exp_pkt) begin
      miscompares++;
      $display("[TB] FAIL trap_thaddr0: got %h expected %h", obs_pkt, exp_pkt);
    end
    send(32'h304, 1, 0, 1, 0, 1);
    exp_pkt = pkt(1, F_SYNC, SF_START, 0, 0, NO_CHANGE, 1, 32'h300, 6'd11);
    vectors++;
    if (obs_pkt !== exp_pkt) begin
      miscompares++;
      $display("[TB] FAIL reported_start: got %h expected %h", obs_pkt, exp_pkt);
    end
    send(32'h308, 1, 0, 1, 0, 1);
    send(32'h400, 1, 1, 1, 0, 1);
    send(32'h500, 1, 0, 1, 0, 1);
    exp_pkt = pkt(1, F_ADDR_ONLY, SF_START, 0, 0, NO_CHANGE, 0, 32'h100, 6'd10);
    vectors++;
    if (obs_pkt !== exp_pkt) begin
      miscompares++;
      $display("[TB] FAIL er_n_second: got %h expected %h", obs_pkt, exp_pkt);
    end
    send(32'h504, 1, 0, 1, 0, 1);
    exp_pkt = pkt(1, F_SYNC, SF_TRAP, 1, 0, NO_CHANGE, 1, 32'h500, 6'd12);
    vectors++;
    if (obs_pkt !== exp_pkt) begin
      miscompares++;
      $display("[TB] FAIL trap_thaddr1: got %h expected %h", obs_pkt, exp_pkt);
    end
  endtask

  task automatic test_resync();
    do_reset();
    send(32'h4000, 1, 0, 1, 0, 0);
    send(32'h4004, 1, 0, 1, 0, 0);
    exp_pkt = pkt(1, F_SYNC, SF_START, 0, 0, NO_CHANGE, 1, 32'h4000, 6'd16);
    vectors++;
    if (obs_pkt !== exp_pkt) begin
      miscompares++;
      $display("[TB] FAIL resync_first: got %h expected %h", obs_pkt, exp_pkt);
    end
    for (int i = 2; i <= 5; i++) begin
      send(32'h4000 + 32'(4 * i), 1, 0, 1, 0, 0);
      vectors++;
      if (valid_o !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL resync_count_%0d: got valid %b expected 0", i, valid_o);
      end
    end
    send(32'h4018, 1, 0, 1, 0, 0);
    exp_pkt = pkt(1, F_DIFF_DELTA, SF_START, 0, 0, NO_CHANGE, 0, 32'h14, 6'd6);
    vectors++;
    if (obs_pkt !== exp_pkt) begin
      miscompares++;
      $display("[TB] FAIL resync_et_max: got %h expected %h", obs_pkt, exp_pkt);
    end
    send(32'h401C, 1, 0, 1, 0, 0);
    exp_pkt = pkt(1, F_SYNC, SF_START, 0, 0, NO_CHANGE, 1, 32'h4018, 6'd16);
    vectors++;
    if (obs_pkt !== exp_pkt) begin
      miscompares++;
      $display("[TB] FAIL resync_gt_max: got %h expected %h", obs_pkt, exp_pkt);
    end
    send(32'h4020, 1, 0, 1, 0, 0);
    vectors++;
    if (valid_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL resync_cleared: got valid %b expected 0", valid_o);
    end
  endtask

  task automatic test_back_to_back_stall();
    do_reset();
    ready_i = 1'b0;
    send(32'h1000, 1, 0, 1, 0, 1);
    send(32'h1004, 1, 0, 1, 0, 1);
    exp_pkt = pkt(1, F_SYNC, SF_START, 0, 0, NO_CHANGE, 1, 32'h1000, 6'd14);
    vectors++;
    if (obs_pkt !== exp_pkt) begin
      miscompares++;
      $display("[TB] FAIL stall_load: got %h expected %h", obs_pkt, exp_pkt);
    end
    iaddr_i = 32'h1008; qualified_i = 1'b0; exception_i = 1'b0; retired_i = 1'b1;
    updiscon_i = 1'b0; branch_map_empty_i = 1'b1; valid_i = 1'b1;
    exp_pkt = pkt(1, F_SYNC, SF_START, 0, 0, NO_CHANGE, 0, 32'h1000, 6'd14);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      vectors++;
      if (ready_o !== 1'b0 || obs_pkt !== exp_pkt) begin
        miscompares++;
        $display("[TB] FAIL stall_hold_%0d: got ready %b pkt %h expected ready 0 pkt %h",
                 i, ready_o, obs_pkt, exp_pkt);
      end
    end
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    exp_pkt = pkt(1, F_ADDR_ONLY, SF_START, 0, 0, NO_CHANGE, 0, 32'h4, 6'd4);
    vectors++;
    if (obs_pkt !== exp_pkt) begin
      miscompares++;
      $display("[TB] FAIL stall_release: got %h expected %h", obs_pkt, exp_pkt);
    end
    @(posedge clk_i); #1;
    vectors++;
    if (valid_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_drain: got valid %b expected 0", valid_o);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    ready_i = 1'b0;
    send(32'h7000, 1, 0, 1, 0, 1);
    send(32'h7004, 1, 0, 1, 0, 1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    vectors++;
    if (valid_o !== 1'b0 || ready_o !== 1'b0 && ready_i === 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_stall: got valid %b expected 0", valid_o);
    end
    vectors++;
    if (ready_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_stall_ready: got %b expected 1", ready_o);
    end
    ready_i = 1'b1;
  endtask

  task automatic test_keep_bits();
    do_reset();
    send(32'hFFFF_FFF0, 1, 0, 1, 1, 1);
    send(32'h0000_0010, 1, 0, 1, 0, 1);
    exp_pkt = pkt(1, F_SYNC, SF_START, 0, 0, NO_CHANGE, 1, 32'hFFFF_FFF0, 6'd5);
    vectors++;
    if (obs_pkt !== exp_pkt) begin
      miscompares++;
      $display("[TB] FAIL keep_neg: got %h expected %h", obs_pkt, exp_pkt);
    end
    send(32'h0000_0014, 1, 0, 1, 0, 1);
    exp_pkt = pkt(1, F_ADDR_ONLY, SF_START, 0, 0, NO_CHANGE, 0, 32'h20, 6'd7);
    vectors++;
    if (obs_pkt !== exp_pkt) begin
      miscompares++;
      $display("[TB] FAIL diff_wrap: got %h expected %h", obs_pkt, exp_pkt);
    end
    do_reset();
    send(32'h0, 1, 0, 1, 0, 1);
    send(32'h4, 1, 0, 1, 0, 1);
    exp_pkt = pkt(1, F_SYNC, SF_START, 0, 0, NO_CHANGE, 1, 32'h0, 6'd1);
    vectors++;
    if (obs_pkt !== exp_pkt) begin
      miscompares++;
      $display("[TB] FAIL keep_zero: got %h expected %h", obs_pkt, exp_pkt);
    end
    do_reset();
    send(32'hFFFF_FFFF, 1, 0, 1, 0, 1);
    send(32'h0, 1, 0, 1, 0, 1);
    exp_pkt = pkt(1, F_SYNC, SF_START, 0, 0, NO_CHANGE, 1, 32'hFFFF_FFFF, 6'd1);
    vectors++;
    if (obs_pkt !== exp_pkt) begin
      miscompares++;
      $display("[TB] FAIL keep_ones: got %h expected %h", obs_pkt, exp_pkt);
    end
  endtask

  initial begin
    test_reset();
    test_first_sync();
    test_updiscon();
    test_exception();
    test_resync();
    test_back_to_back_stall();
    test_reset_mid_stall();
    test_keep_bits();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
